if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Parametrised IF->ID decoupling queue; successor to the single-entry IF/ID register.
//  Buffers up to DEPTH fetched instructions with addr, branch-predict bit and interrupt flags.
//  Valid/ready handshake on both sides; flush on redirect/hold.
//  Sits between the fetch unit and id; lets fetch run ahead while decode stalls.
// PARAMETERS
//  DEPTH   4   entries; power of 2, >=2
//  INST_W  32  instruction width
//  ADDR_W  32  instruction address width
//  INT_W   8   interrupt flag width
// PORTS
//  clk           in   1                clock
//  rst           in   1                synchronous reset, active-high
//  flush_i       in   1                discard all entries (jump/hold >= Hold_If)
//  in_valid_i    in   1                fetch presents entry
//  in_ready_o    out  1                queue can accept (count != DEPTH)
//  inst_i        in   INST_W           instruction
//  inst_addr_i   in   ADDR_W           instruction address
//  prdt_taken_i  in   1                predicted-taken bit
//  int_flag_i    in   INT_W            interrupt flags
//  out_valid_o   out  1                head entry valid
//  out_ready_i   in   1                decode consumes head (0 = stall)
//  inst_o        out  INST_W           head instruction; INST_NOP when !out_valid_o
//  inst_addr_o   out  ADDR_W           head address; 0 when !out_valid_o
//  prdt_taken_o  out  1                head predict bit; 0 when !out_valid_o
//  int_flag_o    out  INT_W            head int flags; INT_NONE when !out_valid_o
//  count_o       out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset (rst=1 at posedge): wr_ptr=rd_ptr=0, count=0; outputs: out_valid_o=0,
//    in_ready_o=1, inst_o=INST_NOP, inst_addr_o=0, prdt_taken_o=0, int_flag_o=INT_NONE, count_o=0.
//    Reset mid-operation drops all entries; reset beats flush beats push/pop.
//  - push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
//  - Storage: circular buffer, ptrs $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//  - Outputs driven combinationally from entry[rd_ptr]; out_valid_o = (count != 0).
//  - Latency push -> visible at head: 1 cycle.
//  - push&!pop: count+1; pop&!push: count-1; push&pop: count unchanged, both ptrs advance.
//  - Full (count==DEPTH): in_ready_o=0 regardless of out_ready_i (no same-cycle full bypass).
//  - Empty: out_valid_o=0, outputs show NOP values; out_ready_i ignored.
//  - flush_i=1: next cycle count=0, ptrs=0; same-cycle push is discarded.
//  - out_ready_i=0 with out_valid_o=1: head and all outputs held stable (stall).
//  - count never exceeds DEPTH and never underflows; assert in sim.
// CONFIGURATION
//  IF_ID_QUEUE_BYPASS_EN defined: when count==0 and in_valid_i=1, input fields drive outputs
//    combinationally and out_valid_o=1 (zero-latency); if out_ready_i=1 the entry is consumed
//    and not stored, else it is written normally. flush_i suppresses bypass (out_valid_o=0).
//  Undefined: no bypass; strict 1-cycle latency as above.
// STRUCTURE
//  Shared defines.v: INST_NOP, ZeroWord, INT_NONE, InstBus/InstAddrBus widths.
//  One sub-module: if_id_queue_mem (DEPTH x {inst,addr,prdt,int} regs, 1 write, 1 async read).
//  Ptr/count control and output muxing stay in if_id_queue.
// TESTING
//  1 Reset: rst=1 2 cycles -> out_valid_o=0, inst_o=32'h00000013, count_o=0, in_ready_o=1.
//  2 Fill: push 4 (addr 0,4,8,C), out_ready_i=0 -> count_o=4, in_ready_o=0, inst_addr_o=0 held.
//  3 Drain order: then out_ready_i=1 4 cycles -> addrs 0,4,8,C in order; count_o=0, NOP outputs.
//  4 Simultaneous: count=2, push+pop 10 cycles -> count_o stays 2, order preserved across wrap.
//  5 Flush: count=3, flush_i=1 with in_valid_i=1 -> next cycle count_o=0, out_valid_o=0.
//  6 Bypass (macro on): empty, push addr 0x100 with out_ready_i=1 -> same-cycle
//    inst_addr_o=0x100, count_o stays 0; macro off -> visible next cycle, count_o=1 then 0.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// Shared constants and payload type for the IF->ID decoupling queue.
package if_id_queue_pkg;

  localparam int unsigned DEF_DEPTH  = 4;
  localparam int unsigned DEF_INST_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_INT_W  = 8;

  localparam logic [DEF_INST_W-1:0] INST_NOP  = 32'h0000_0013;
  localparam logic [DEF_ADDR_W-1:0] ZERO_WORD = '0;
  localparam logic [DEF_INT_W-1:0]  INT_NONE  = '0;

  // One fetched instruction as carried from IF to ID
  typedef struct packed {
    logic [DEF_INST_W-1:0] inst;
    logic [DEF_ADDR_W-1:0] addr;
    logic                  prdt;
    logic [DEF_INT_W-1:0]  int_flag;
  } if_id_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-side and decode-side handshake bundle of the IF->ID queue.
interface if_id_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INT_W  = 8
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [INST_W-1:0] inst_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic              prdt_taken_i;
  logic [INT_W-1:0]  int_flag_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              prdt_taken_o;
  logic [INT_W-1:0]  int_flag_o;
  logic [CNT_W-1:0]  count_o;

  modport master (
    output in_valid_i, inst_i, inst_addr_i, prdt_taken_i, int_flag_i, out_ready_i,
    input  in_ready_o, out_valid_o, inst_o, inst_addr_o, prdt_taken_o, int_flag_o, count_o
  );

  modport slave (
    input  in_valid_i, inst_i, inst_addr_i, prdt_taken_i, int_flag_i, out_ready_i,
    output in_ready_o, out_valid_o, inst_o, inst_addr_o, prdt_taken_o, int_flag_o, count_o
  );
endinterface

// File: rtl/if_id_queue_mem.sv
// Entry storage for the IF->ID queue: DEPTH registers, one write port, one async read port.
module if_id_queue_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned INT_W  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [INST_W-1:0]        i_inst,
  input  logic [ADDR_W-1:0]        i_addr,
  input  logic                     i_prdt,
  input  logic [INT_W-1:0]         i_int_flag,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [INST_W-1:0]        o_inst,
  output logic [ADDR_W-1:0]        o_addr,
  output logic                     o_prdt,
  output logic [INT_W-1:0]         o_int_flag
);

  logic [INST_W-1:0] r_inst     [DEPTH];
  logic [ADDR_W-1:0] r_addr     [DEPTH];
  logic              r_prdt     [DEPTH];
  logic [INT_W-1:0]  r_int_flag [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_inst[i_waddr]     <= i_inst;
      r_addr[i_waddr]     <= i_addr;
      r_prdt[i_waddr]     <= i_prdt;
      r_int_flag[i_waddr] <= i_int_flag;
    end
  end

  assign o_inst     = r_inst[i_raddr];
  assign o_addr     = r_addr[i_raddr];
  assign o_prdt     = r_prdt[i_raddr];
  assign o_int_flag = r_int_flag[i_raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF->ID decoupling queue: lets fetch run ahead while decode stalls.
// Optional zero-latency empty-queue bypass under IF_ID_QUEUE_BYPASS_EN.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned INST_W = DEF_INST_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned INT_W  = DEF_INT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  if_id_queue_if.slave q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_bypass;
  logic              w_wr_en;
  logic              w_rd_adv;
  logic              w_mem_we;
  logic [INST_W-1:0] w_mem_inst;
  logic [ADDR_W-1:0] w_mem_addr;
  logic              w_mem_prdt;
  logic [INT_W-1:0]  w_mem_int_flag;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  assign q.in_ready_o = !w_full;
  assign q.count_o    = r_count;
  assign w_push       = q.in_valid_i & !w_full;

`ifdef IF_ID_QUEUE_BYPASS_EN
  assign w_bypass = w_empty & q.in_valid_i & !flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  assign q.out_valid_o = !w_empty | w_bypass;
  assign w_pop         = q.out_valid_o & q.out_ready_i;

  // A bypassed entry taken by decode the same cycle never touches storage
  assign w_wr_en  = w_push & !(w_bypass & q.out_ready_i);
  assign w_rd_adv = w_pop & !w_bypass;
  assign w_mem_we = w_wr_en & !flush_i & !rst;

  if_id_queue_mem #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W),
    .ADDR_W (ADDR_W),
    .INT_W  (INT_W)
  ) u_mem (
    .clk        (clk),
    .i_we       (w_mem_we),
    .i_waddr    (r_wr_ptr),
    .i_inst     (q.inst_i),
    .i_addr     (q.inst_addr_i),
    .i_prdt     (q.prdt_taken_i),
    .i_int_flag (q.int_flag_i),
    .i_raddr    (r_rd_ptr),
    .o_inst     (w_mem_inst),
    .o_addr     (w_mem_addr),
    .o_prdt     (w_mem_prdt),
    .o_int_flag (w_mem_int_flag)
  );

  // Head view: NOP values whenever nothing valid is presented
  always_comb begin
    q.inst_o       = INST_W'(INST_NOP);
    q.inst_addr_o  = ADDR_W'(ZERO_WORD);
    q.prdt_taken_o = 1'b0;
    q.int_flag_o   = INT_W'(INT_NONE);
    if (w_bypass) begin
      q.inst_o       = q.inst_i;
      q.inst_addr_o  = q.inst_addr_i;
      q.prdt_taken_o = q.prdt_taken_i;
      q.int_flag_o   = q.int_flag_i;
    end else if (!w_empty) begin
      q.inst_o       = w_mem_inst;
      q.inst_addr_o  = w_mem_addr;
      q.prdt_taken_o = w_mem_prdt;
      q.int_flag_o   = w_mem_int_flag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_adv) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_wr_en, w_rd_adv})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Occupancy must stay within 0..DEPTH
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (r_count <= CNT_W'(DEPTH));
      assert (!(w_empty && w_rd_adv));
      assert (!(w_full && w_wr_en));
    end
  end

endmodule
